// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial adder datapath.
// Holds the collector state encoding and counter sizing.
package serial_pkg;

    localparam int SERIAL_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } coll_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Serial-to-parallel shift register for the sum collector.
// clear restarts the word; a coincident shift_en loads bit 0.
module serial_shift_in #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_seed;

    if (MSB_FIRST != 0) begin : g_msb
        assign w_shifted = {r_word[WIDTH-2:0], bit_in};
        assign w_seed    = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin : g_lsb
        assign w_shifted = {bit_in, r_word[WIDTH-1:1]};
        assign w_seed    = {bit_in, {(WIDTH-1){1'b0}}};
    end

    // Shift register update: clear (optionally seeding bit 0) or shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
        end else if (clear) begin
            r_word <= shift_en ? w_seed : '0;
        end else if (shift_en) begin
            r_word <= w_shifted;
        end
    end

    assign word = r_word;

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the bit-serial adder output into parallel words.
// Optional carry capture enabled by SERIAL_SUM_CARRY_EN.
module serial_sum_collector
    import serial_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH_DEF,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             cout_bit,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
`ifdef SERIAL_SUM_CARRY_EN
    output logic             carry_out,
`endif
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = cnt_width(WIDTH);

    coll_state_t r_state;
    logic [CW-1:0] r_count;
    logic r_word_valid;
    logic r_busy;
    logic r_frame_err;

    logic w_restart;
    logic w_shift;
    logic w_last;

    // Start is honoured everywhere except HOLD without a handshake
    assign w_restart = start &&
                       ((r_state != HOLD) || word_ready);
    assign w_shift   = bit_valid &&
                       (w_restart || (r_state == COLLECT));
    assign w_last    = (r_state == COLLECT) && !start &&
                       bit_valid &&
                       (r_count == CW'(WIDTH - 1));

    serial_shift_in #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_restart),
        .shift_en (w_shift),
        .bit_in   (sum_bit),
        .word     (word_out)
    );

    // Framing FSM: bit count, completion and output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= start && (r_state == COLLECT);
            if (w_restart) begin
                r_state      <= COLLECT;
                r_busy       <= 1'b1;
                r_word_valid <= 1'b0;
                r_count      <= bit_valid ? CW'(1) : '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_count <= '0;
                    end
                    COLLECT: begin
                        if (w_last) begin
                            r_state      <= HOLD;
                            r_word_valid <= 1'b1;
                            r_count      <= '0;
                        end else if (bit_valid) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (word_ready) begin
                            r_state      <= IDLE;
                            r_word_valid <= 1'b0;
                            r_busy       <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_word_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_valid = r_word_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;

`ifdef SERIAL_SUM_CARRY_EN
    logic r_carry;

    // Carry of the final accepted bit, held with the word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry <= 1'b0;
        end else if (w_last) begin
            r_carry <= cout_bit;
        end
    end

    assign carry_out = r_carry;
`else
    logic w_unused_cout;
    assign w_unused_cout = cout_bit;
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// Bench for serial_sum_collector: LSB-first and MSB-first
// instances share one stimulus stream against a frame model.
module tb_serial_sum_collector;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    logic start, bit_valid, sum_bit, cout_bit, word_ready;

    logic [W-1:0] wo0, wo1;
    logic wv0, wv1, b0, b1, fe0, fe1;
`ifdef SERIAL_SUM_CARRY_EN
    logic co0, co1;
`endif

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    serial_sum_collector #(.WIDTH(W), .MSB_FIRST(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_valid  (bit_valid),
        .sum_bit    (sum_bit),
        .cout_bit   (cout_bit),
        .word_ready (word_ready),
        .word_out   (wo0),
`ifdef SERIAL_SUM_CARRY_EN
        .carry_out  (co0),
`endif
        .word_valid (wv0),
        .busy       (b0),
        .frame_err  (fe0)
    );

    serial_sum_collector #(.WIDTH(W), .MSB_FIRST(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_valid  (bit_valid),
        .sum_bit    (sum_bit),
        .cout_bit   (cout_bit),
        .word_ready (word_ready),
        .word_out   (wo1),
`ifdef SERIAL_SUM_CARRY_EN
        .carry_out  (co1),
`endif
        .word_valid (wv1),
        .busy       (b1),
        .frame_err  (fe1)
    );

    // Bits are sent data[0] first; place them by arrival order
    function automatic logic [W-1:0] exp_word(
        input logic [W-1:0] d, input bit msb);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) r[W-1-i] = d[i];
            else     r[i]     = d[i];
        end
        return r;
    endfunction

    task automatic cyc(input logic s, input logic bv,
                       input logic sb, input logic cb,
                       input logic wr);
        logic pv;
        start = s; bit_valid = bv; sum_bit = sb;
        cout_bit = cb; word_ready = wr;
        pv = wv0;
        @(posedge clk); #1;
        if (pv && wr) xfers++;
        if (fe0) err_pulses++;
    endtask

    // gap: 0 none, 1 alternate, 2 random
    task automatic send_bits(input logic [W-1:0] d,
                             input int from, input int to,
                             input int gap, input logic lc);
        for (int i = from; i < to; i++) begin
            if ((gap == 1 && i != from) ||
                (gap == 2 && $urandom_range(0, 2) == 0))
                cyc(0, 0, 1'($urandom), 1'($urandom),
                    1'($urandom));
            cyc(0, 1, d[i],
                (i == W-1) ? lc : 1'($urandom),
                1'($urandom));
        end
    endtask

    task automatic chk_word(input string nm,
                            input logic [W-1:0] d);
        checks++;
        if (wv0 !== 1'b1 || wo0 !== exp_word(d, 0)) begin
            errors++;
            $display("FAIL %s lsb: valid=%b word=%h want 1/%h",
                     nm, wv0, wo0, exp_word(d, 0));
        end
        checks++;
        if (wv1 !== 1'b1 || wo1 !== exp_word(d, 1)) begin
            errors++;
            $display("FAIL %s msb: valid=%b word=%h want 1/%h",
                     nm, wv1, wo1, exp_word(d, 1));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 0; bit_valid = 0; sum_bit = 0;
        cout_bit = 0; word_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wo0, wv0, b0, fe0, wo1, wv1, b1, fe1} !== '0) begin
            errors++;
            $display("FAIL reset: %h %b%b%b %h %b%b%b want 0",
                     wo0, wv0, b0, fe0, wo1, wv1, b1, fe1);
        end
`ifdef SERIAL_SUM_CARRY_EN
        checks++;
        if ({co0, co1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_carry: %b%b want 00", co0, co1);
        end
`endif
        reset = 1'b0;
        cyc(0, 1, 1, 1, 1);
        checks++;
        if (b0 !== 1'b0 || wo0 !== '0) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b word=%h want 0/0",
                     b0, wo0);
        end
    endtask

    task automatic test_basic();
        int x0;
        x0 = xfers;
        cyc(1, 0, 0, 0, 1);
        send_bits(8'h5A, 0, W, 0, 0);
        chk_word("basic", 8'h5A);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (wv0 !== 0 || b0 !== 0 || xfers - x0 !== 1) begin
            errors++;
            $display("FAIL basic_done: v=%b busy=%b xf=%0d want 0/0/1",
                     wv0, b0, xfers - x0);
        end
        checks++;
        if (wo0 !== 8'h5A) begin
            errors++;
            $display("FAIL idle_retain: %h want 5a", wo0);
        end
    endtask

    task automatic test_gaps_hold();
        int x0;
        x0 = xfers;
        cyc(1, 0, 0, 0, 0);
        send_bits(8'h5A, 0, W, 1, 0);
        for (int k = 0; k < 5; k++) begin
            chk_word("hold", 8'h5A);
            cyc(k == 2, 1, 1'($urandom), 0, 0);
        end
        chk_word("hold_end", 8'h5A);
        checks++;
        if (b0 !== 1 || xfers != x0 || fe0 !== 0) begin
            errors++;
            $display("FAIL hold_busy: busy=%b xf=%0d fe=%b want 1/0/0",
                     b0, xfers - x0, fe0);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (wv0 !== 0 || xfers - x0 !== 1) begin
            errors++;
            $display("FAIL hold_xfer: v=%b xf=%0d want 0/1",
                     wv0, xfers - x0);
        end
    endtask

    task automatic test_abort();
        int e0;
        e0 = err_pulses;
        cyc(1, 0, 0, 0, 0);
        send_bits(8'h00, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (fe0 !== 1 || fe1 !== 1) begin
            errors++;
            $display("FAIL abort_pulse: %b%b want 11", fe0, fe1);
        end
        send_bits(8'hFF, 0, W, 0, 1);
        checks++;
        if (err_pulses - e0 !== 1) begin
            errors++;
            $display("FAIL abort_width: pulses=%0d want 1",
                     err_pulses - e0);
        end
        chk_word("abort", 8'hFF);
        cyc(0, 0, 0, 0, 1);
        e0 = err_pulses;
        cyc(1, 0, 0, 0, 0);
        send_bits(8'h00, 0, 5, 0, 0);
        cyc(1, 1, 1'(8'hA7 & 1), 0, 0);
        send_bits(8'hA7, 1, W, 2, 0);
        checks++;
        if (err_pulses - e0 !== 1) begin
            errors++;
            $display("FAIL abort_bit0: pulses=%0d want 1",
                     err_pulses - e0);
        end
        chk_word("abort_bit0", 8'hA7);
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d2;
        int x0;
        d2 = 8'h34;
        x0 = xfers;
        cyc(1, 0, 0, 0, 0);
        send_bits(8'h12, 0, W, 0, 0);
        chk_word("b2b_first", 8'h12);
        cyc(1, 1, d2[0], 0, 1);
        checks++;
        if (b0 !== 1 || wv0 !== 0 || fe0 !== 0) begin
            errors++;
            $display("FAIL b2b_turn: busy=%b v=%b fe=%b want 1/0/0",
                     b0, wv0, fe0);
        end
        send_bits(d2, 1, W, 0, 0);
        chk_word("b2b_second", d2);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (xfers - x0 !== 2 || b0 !== 0) begin
            errors++;
            $display("FAIL b2b_count: xf=%0d busy=%b want 2/0",
                     xfers - x0, b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        int e0;
        d = 8'hC3;
        cyc(1, 0, 0, 0, 0);
        send_bits(8'hFF, 0, 4, 0, 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wo0, wv0, b0, fe0, wo1, wv1, b1, fe1} !== '0) begin
            errors++;
            $display("FAIL mid_reset: %h %b%b%b %h %b%b%b want 0",
                     wo0, wv0, b0, fe0, wo1, wv1, b1, fe1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        e0 = err_pulses;
        cyc(1, 1, d[0], 0, 0);
        send_bits(d, 1, W, 0, 0);
        chk_word("after_reset", d);
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL after_reset_err: pulses=%0d want 0",
                     err_pulses - e0);
        end
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_carry();
        cyc(1, 0, 0, 0, 0);
        send_bits(8'h81, 0, W, 0, 1);
        chk_word("carry_frame", 8'h81);
`ifdef SERIAL_SUM_CARRY_EN
        checks++;
        if (co1 !== 1 || co0 !== 1) begin
            errors++;
            $display("FAIL carry: %b%b want 11", co0, co1);
        end
`endif
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic lc;
        int hold;
        for (int f = 0; f < 30; f++) begin
            d = W'($urandom);
            lc = 1'($urandom);
            hold = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                cyc(1, 1, d[0], 1'($urandom), 0);
                send_bits(d, 1, W, 2, lc);
            end else begin
                cyc(1, 0, 1'($urandom), 0, 0);
                send_bits(d, 0, W, 2, lc);
            end
            for (int k = 0; k < hold; k++)
                cyc(0, 1'($urandom), 1'($urandom), 0, 0);
            chk_word("rand", d);
`ifdef SERIAL_SUM_CARRY_EN
            checks++;
            if (co0 !== lc || co1 !== lc) begin
                errors++;
                $display("FAIL rand_carry: %b%b want %b",
                         co0, co1, lc);
            end
`endif
            cyc(0, 0, 0, 0, 1);
            for (int k = 0; k < $urandom_range(0, 2); k++)
                cyc(0, 1'($urandom), 1'($urandom), 0, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_hold();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_carry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
